// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and multiplier-sequencer state encoding.
// Used by the core's shared ALU and by alu_mul_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SRL    = 4'b0011,
    ALU_SRA    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_XOR    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SHL  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add MUL sequencer that borrows the core's shared ALU (low 32 bits of product).
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            alu_own,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_res,
  output logic            busy,
  output mul_state_e      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and its payload stay stable until that edge.

  mul_state_e      state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [4:0]      cnt;
  logic            skip_zero;
  logic            last_shl;

`ifdef MUL_EARLY_EXIT_EN
  assign skip_zero = (req_b == '0);
  assign last_shl  = (cnt == 5'd31) || (mplier[XLEN-1:1] == '0);
`else
  assign skip_zero = 1'b0;
  assign last_shl  = (cnt == 5'd31);
`endif

  assign dbg_state = state;

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      alu_own   <= 1'b0;
      alu_op    <= 4'b0000;
      alu_a     <= '0;
      alu_b     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mcand     <= req_a;
            mplier    <= req_b;
            acc       <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (skip_zero) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state   <= ST_ADD;
              alu_own <= 1'b1;
              alu_op  <= ALU_ADD;
              alu_a   <= '0;
              alu_b   <= req_a;
            end
          end
        end
        ST_ADD: begin
          if (mplier[0]) acc <= alu_res;
          state  <= ST_SHL;
          alu_op <= ALU_SLL;
          alu_a  <= mcand;
          alu_b  <= XLEN'(1);
        end
        ST_SHL: begin
          mcand  <= alu_res;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_shl) begin
            state     <= ST_DONE;
            alu_own   <= 1'b0;
            alu_op    <= 4'b0000;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= acc;
          end else begin
            state  <= ST_ADD;
            alu_op <= ALU_ADD;
            alu_a  <= acc;
            alu_b  <= alu_res;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
// Build with +define+MUL_EARLY_EXIT_EN to exercise the early-exit latencies.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        alu_own;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        busy;
  mul_state_e  dbg_state;

  int errors = 0;
  int checks = 0;

  alu_mul_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_own   (alu_own),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // shared ALU model
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a - alu_b;
      4'b0010: alu_res = alu_a << alu_b[4:0];
      4'b0011: alu_res = alu_a >> alu_b[4:0];
      4'b0100: alu_res = $signed(alu_a) >>> alu_b[4:0];
      4'b0101: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0110: alu_res = {31'd0, alu_a < alu_b};
      4'b0111: alu_res = alu_a ^ alu_b;
      4'b1000: alu_res = alu_a | alu_b;
      4'b1001: alu_res = alu_a & alu_b;
      4'b1010: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // expected cycle (after acceptance) in which rsp_valid rises
  function automatic int lat_of(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    if (b == 0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return 2 * (msb + 1) + 1;
`else
    return 65;
`endif
  endfunction

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
  endtask

  // driver: issue one multiply, check latency/data, then accept the product
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit trace);
    int lat;
    logic [31:0] exp_p;
    exp_p = a * b;
    lat = 0;
    while (!req_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (trace && lat == 1) begin
        check({tag, "_c1_own"}, {31'd0, alu_own}, 32'd1);
        check({tag, "_c1_op"}, {28'd0, alu_op}, 32'h0);
        check({tag, "_c1_a"}, alu_a, 32'd0);
        check({tag, "_c1_b"}, alu_b, a);
      end
      if (trace && lat == 2) begin
        check({tag, "_c2_op"}, {28'd0, alu_op}, 32'h2);
        check({tag, "_c2_a"}, alu_a, a);
        check({tag, "_c2_b"}, alu_b, 32'd1);
      end
      if (trace && lat == 3) begin
        check({tag, "_c3_op"}, {28'd0, alu_op}, 32'h0);
        check({tag, "_c3_a"}, alu_a, b[0] ? a : 32'd0);
        check({tag, "_c3_b"}, alu_b, a << 1);
      end
      if (trace && lat == 4) begin
        check({tag, "_c4_op"}, {28'd0, alu_op}, 32'h2);
        check({tag, "_c4_b"}, alu_b, 32'd1);
      end
      if (rsp_valid) break;
    end
    check({tag, "_lat"}, lat, lat_of(b));
    check({tag, "_data"}, rsp_data, exp_p);
    check({tag, "_done_own"}, {31'd0, alu_own}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_after_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int vcount;
    logic [31:0] held;

    // reset with no clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_alu_own", {31'd0, alu_own}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    mul_op("m7x6", 32'd7, 32'd6, 1'b1);
    mul_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    mul_op("mwrap", 32'h8000_0000, 32'd2, 1'b0);
    mul_op("m5x0", 32'd5, 32'd0, 1'b0);
    mul_op("m5x3", 32'd5, 32'd3, 1'b0);
    mul_op("m1x80", 32'd1, 32'h8000_0000, 1'b0);
    mul_op("mmix", 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);

    // backpressure then a request presented during the accepting cycle
    @(negedge clk);
    req_a = 32'h1234_5678;
    req_b = 32'h10;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_lat", lat, lat_of(32'h10));
    check("bp_data", rsp_data, 32'h2345_6780);
    held = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_data", rsp_data, held);
      check("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_hold_own", {31'd0, alu_own}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_a = 32'd3;
    req_b = 32'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    check("bubble_busy", {31'd0, busy}, 32'd0);
    check("bubble_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_rsp(lat);
    check("b2b_lat", lat, lat_of(32'd3));
    check("b2b_data", rsp_data, 32'd9);
    @(posedge clk);
    #1;

    // reset in cycle 20 of a 7x6 operation
    @(negedge clk);
    req_a = 32'd7;
    req_b = 32'd6;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_own", {31'd0, alu_own}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid) vcount++;
    end
    check("mid_rst_no_rsp", vcount, 32'd0);
    mul_op("m3x3", 32'd3, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
